// File: rtl/tap_pkg.sv
// Shared boundary-scan definitions.
//   tap_instr_e : TAP instruction opcodes that the decoder can issue
//   CELL_IN     : cell direction pad -> core
//   CELL_OUT    : cell direction core -> pad
package tap_pkg;

  typedef enum logic [3:0] {
    INSTR_EXTEST  = 4'b0000,
    INSTR_SAMPLE  = 4'b0001,
    INSTR_PRELOAD = 4'b0010,
    INSTR_INTEST  = 4'b0011,
    INSTR_BYPASS  = 4'b1111
  } tap_instr_e;

  localparam logic CELL_IN  = 1'b0;
  localparam logic CELL_OUT = 1'b1;

endpackage

// File: rtl/tap_bs_slice.sv
// One boundary-scan cell: shift flop (posedge), update flop (negedge) and
// the functional/test output mux. DIR selects output (core->pad) or input
// (pad->core) behaviour.
// Ports:
//   trst       async active-low reset
//   clock_dr   DR clock
//   capture_en load capture value (already qualified by chain select)
//   shift_en   load scan_data (already qualified by chain select)
//   update_en  copy shift flop into update flop on falling edge
//   extest     drive pad from update flop (output cells)
//   intest     drive core from update flop, capture core side (input cells)
//   scan_data  serial input from the next-higher cell (or si for the MSB)
//   core_val   core-side functional value
//   pad_val    pad-side functional value
//   sr         shift flop state (serial output toward the LSB)
//   pad_drive  value to the pad (0 for input cells)
//   core_drive value to the core (0 for output cells)
module tap_bs_slice
  import tap_pkg::*;
#(
  parameter logic DIR     = CELL_IN,
  parameter logic UPD_RST = 1'b0
) (
  input  logic trst,
  input  logic clock_dr,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic extest,
  input  logic intest,
  input  logic scan_data,
  input  logic core_val,
  input  logic pad_val,
  output logic sr,
  output logic pad_drive,
  output logic core_drive
);

  logic ur;
  logic cap;

  // Input cells under INTEST observe the core-side response instead of the pad.
  always_comb begin
    cap = pad_val;
    if (DIR == CELL_OUT || intest) cap = core_val;
  end

  always_ff @(posedge clock_dr or negedge trst) begin
    if (!trst)           sr <= 1'b0;
    else if (capture_en) sr <= cap;
    else if (shift_en)   sr <= scan_data;
  end

  always_ff @(negedge clock_dr or negedge trst) begin
    if (!trst)          ur <= UPD_RST;
    else if (update_en) ur <= sr;
  end

  always_comb begin
    pad_drive  = 1'b0;
    core_drive = 1'b0;
    if (DIR == CELL_OUT) pad_drive  = extest ? ur : core_val;
    else                 core_drive = intest ? ur : pad_val;
  end

endmodule

// File: rtl/tap_bs_chain.sv
// Parametrised boundary-scan register of WIDTH cells between si_i and so_o.
// Supports SAMPLE, PRELOAD, EXTEST and INTEST; shift on posedge clockDR_i,
// update on negedge clockDR_i. LSB shifts out first, si_i enters the MSB.
// Ports:
//   trst_i        async active-low TAP reset
//   clockDR_i     DR clock
//   captureDR_i   Capture-DR state
//   shiftDR_i     Shift-DR state
//   updateDR_i    Update-DR state
//   sample_i, preload_i, extest_i, intest_i  decoded instruction strobes
//   si_i / so_o   serial in / out
//   core_i        core-side functional values (output cells)
//   pad_i         pad-side functional values (input cells)
//   pad_o         to pads
//   core_o        to core
module tap_bs_chain
  import tap_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] DIR_MASK = 8'hF0,
  parameter logic [WIDTH-1:0] UPD_RST  = '0
) (
  input  logic             trst_i,
  input  logic             clockDR_i,
  input  logic             captureDR_i,
  input  logic             shiftDR_i,
  input  logic             updateDR_i,
  input  logic             sample_i,
  input  logic             preload_i,
  input  logic             extest_i,
  input  logic             intest_i,
  input  logic             si_i,
  output logic             so_o,
  input  logic [WIDTH-1:0] core_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] core_o
);

  logic             sel;
  logic             capture_en;
  logic             shift_en;
  logic             update_en;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shift_src;

  // Capture has priority over shift inside each slice.
  always_comb begin
    sel        = sample_i | preload_i | extest_i | intest_i;
    capture_en = sel & captureDR_i;
    shift_en   = sel & shiftDR_i;
    // SAMPLE alone never loads the update stage.
    update_en  = updateDR_i & (preload_i | extest_i | intest_i);
  end

  generate
    if (WIDTH == 1) begin : g_single
      assign shift_src = si_i;
    end else begin : g_multi
      assign shift_src = {si_i, sr[WIDTH-1:1]};
    end
  endgenerate

  assign so_o = sr[0];

  generate
    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
      tap_bs_slice #(
        .DIR     (DIR_MASK[k]),
        .UPD_RST (UPD_RST[k])
      ) u_slice (
        .trst       (trst_i),
        .clock_dr   (clockDR_i),
        .capture_en (capture_en),
        .shift_en   (shift_en),
        .update_en  (update_en),
        .extest     (extest_i),
        .intest     (intest_i),
        .scan_data  (shift_src[k]),
        .core_val   (core_i[k]),
        .pad_val    (pad_i[k]),
        .sr         (sr[k]),
        .pad_drive  (pad_o[k]),
        .core_drive (core_o[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tap_bs_chain.sv
module tb_tap_bs_chain;

  logic       trst;
  logic       clk;
  logic       capture_dr, shift_dr, update_dr;
  logic       sample, preload, extest, intest;
  logic       si;
  logic       so;
  logic [7:0] core_in, pad_in;
  logic [7:0] pad_out, core_out;

  int unsigned n_cmp;
  int unsigned n_bad;
  logic [7:0]  shifted;

  tap_bs_chain #(
    .WIDTH    (8),
    .DIR_MASK (8'hF0),
    .UPD_RST  (8'h00)
  ) dut (
    .trst_i      (trst),
    .clockDR_i   (clk),
    .captureDR_i (capture_dr),
    .shiftDR_i   (shift_dr),
    .updateDR_i  (update_dr),
    .sample_i    (sample),
    .preload_i   (preload),
    .extest_i    (extest),
    .intest_i    (intest),
    .si_i        (si),
    .so_o        (so),
    .core_i      (core_in),
    .pad_i       (pad_in),
    .pad_o       (pad_out),
    .core_o      (core_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic shift8(input logic [7:0] din, output logic [7:0] dout);
    shift_dr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dout[i] = so;
      si      = din[i];
      tick();
    end
    shift_dr = 1'b0;
    si       = 1'b0;
  endtask

  task automatic update();
    update_dr = 1'b1;
    @(negedge clk);
    #1;
    update_dr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    trst = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    sample = 1'b0; preload = 1'b0; extest = 1'b0; intest = 1'b0;
    si = 1'b0;
    core_in = 8'h5A;
    pad_in  = 8'h3C;

    // Reset and functional pass-through
    #23 trst = 1'b1;
    #1;
    chk("reset_so", {7'b0, so}, 8'h00);
    chk("reset_pad_o", pad_out, 8'h50);
    chk("reset_core_o", core_out, 8'h0C);

    // SAMPLE: capture {core[7:4], pad[3:0]} and shift out LSB first
    core_in = 8'hA0;
    pad_in  = 8'h05;
    sample  = 1'b1;
    tick();
    capture();
    shift8(8'h00, shifted);
    chk("sample_shift_out", shifted, 8'hA5);
    chk("sample_pad_o", pad_out, 8'hA0);
    chk("sample_core_o", core_out, 8'h05);

    // PRELOAD 3C, update, then EXTEST drives it
    sample  = 1'b0;
    preload = 1'b1;
    shift8(8'h3C, shifted);
    chk("preload_shift_out", shifted, 8'h00);
    update();
    chk("preload_pad_o_no_extest", pad_out, 8'hA0);
    preload = 1'b0;
    extest  = 1'b1;
    #1;
    chk("extest_pad_o", pad_out, 8'h30);
    chk("extest_core_o", core_out, 8'h05);

    // EXTEST: update becomes visible only at the falling edge
    tick();
    shift8(8'hC3, shifted);
    chk("extest_shift_out", shifted, 8'h3C);
    update_dr = 1'b1;
    #1;
    chk("extest_before_negedge", pad_out, 8'h30);
    @(negedge clk);
    #1;
    update_dr = 1'b0;
    chk("extest_after_negedge", pad_out, 8'hC0);

    // INTEST: drive core from update stage; input cells capture core side
    extest = 1'b0;
    intest = 1'b1;
    shift8(8'h0F, shifted);
    chk("intest_shift_out", shifted, 8'hC3);
    update();
    chk("intest_core_o", core_out, 8'h0F);
    chk("intest_pad_o", pad_out, 8'hA0);
    core_in = 8'h09;
    tick();
    capture();
    shift8(8'h00, shifted);
    chk("intest_capture", shifted, 8'h09);

    // SAMPLE alone must not load the update stage
    intest = 1'b0;
    sample = 1'b1;
    shift8(8'hF0, shifted);
    chk("sample2_shift_out", shifted, 8'h00);
    update();
    sample = 1'b0;
    intest = 1'b1;
    #1;
    chk("sample_no_update", core_out, 8'h0F);

    // Capture and shift on the same edge: capture wins
    intest  = 1'b0;
    sample  = 1'b1;
    core_in = 8'h81;
    pad_in  = 8'h06;
    tick();
    capture_dr = 1'b1;
    shift_dr   = 1'b1;
    si         = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    si         = 1'b0;
    shift8(8'h00, shifted);
    chk("capture_priority", shifted, 8'h86);

    // Reset mid-shift under EXTEST
    sample  = 1'b0;
    extest  = 1'b1;
    core_in = 8'hA0;
    shift8(8'hFF, shifted);
    chk("rst_pre_shift_out", shifted, 8'h00);
    update();
    chk("rst_pre_pad_o", pad_out, 8'hF0);
    tick();
    shift_dr = 1'b1;
    si       = 1'b1;
    tick(); tick(); tick();
    #2 trst = 1'b0;
    #1;
    chk("rst_mid_pad_o", pad_out, 8'h00);
    chk("rst_mid_so", {7'b0, so}, 8'h00);
    shift_dr = 1'b0;
    si       = 1'b0;
    extest   = 1'b0;
    #1;
    chk("rst_passthrough_pad_o", pad_out, 8'hA0);
    #2 trst = 1'b1;
    sample = 1'b1;
    tick();
    shift8(8'h00, shifted);
    chk("rst_sr_cleared", shifted, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
